cnn_tile_ctrl: RTL
==================

CNN_TILE_CTRL -- requirements
Module: cnn_tile_ctrl

Interface
REQ-001 SHALL have parameter W_SIZE, default 9: width of row/column dimensions and indices.
REQ-002 SHALL have parameter W_CHANNEL, default 5: width of channel-tile counts and indices.
REQ-003 SHALL have parameter W_FRAME_SIZE, default 24: width of the data counter.
REQ-004 SHALL have parameter W_IFM_BUF, default 2: IFM ring-slot index width; IFM_BUF_CNT = 2^W_IFM_BUF (minimum 4).
REQ-005 SHALL have parameter HSYNC_DLY, default 4: idle cycles before each data row.
REQ-006 SHALL have these ports:
- clk  in  1  clock; one clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- i_start  in  1  start pulse.
- i_width, i_height  in  W_SIZE  IFM dimensions.
- i_in_chn  in  W_CHANNEL  input channel tiles.
- i_out_chn  in  W_CHANNEL  output channel tiles.
- i_stride2  in  1  1 = stride 2.
- i_k1x1  in  1  1 = 1x1 kernel, 0 = 3x3.
- i_ifm_buf_done, i_filter_buf_done, i_pe_done  in  1  completion pulses.
- o_busy  out  1  run in progress.
- o_filter_req_load  out  1  filter load pulse.
- o_filter_req_tile  out  W_CHANNEL  output tile to load.
- o_ifm_req_load  out  1  IFM row load pulse.
- o_ifm_req_row  out  W_SIZE  input row to load.
- o_ifm_req_slot  out  W_IFM_BUF  destination ring slot.
- o_hsync_run, o_data_run  out  1  phase flags.
- o_row, o_col  out  W_SIZE  output position.
- o_chn, o_otile  out  W_CHANNEL  input tile and output tile.
- o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col, o_is_first_chn, o_is_last_chn  out  1  boundary flags.
- o_data_count  out  W_FRAME_SIZE  data beats issued.
- o_end_frame  out  1  completion pulse.

Function
REQ-007 SHALL compute the output size at start: OH = i_stride2 ? (i_height+1)>>1 : i_height; OW likewise from i_width.
REQ-008 SHALL implement the FSM states IDLE, LOAD_FILT, HSYNC, DATA, WAIT_PE and DONE.
REQ-009 SHALL transition IDLE -> LOAD_FILT on i_start, latching all configuration inputs at that point.
REQ-010 SHALL ignore i_start when o_busy = 1.
REQ-011 SHALL, on i_start with any of width, height, in_chn or out_chn equal to 0, pulse o_end_frame in the next cycle, issue no requests and stay IDLE.
REQ-012 SHALL assert o_filter_req_load for 1 cycle on entering LOAD_FILT, with o_filter_req_tile = o_otile; the pulse occurs in cycle t+1 for i_start in cycle t.
REQ-013 SHALL leave LOAD_FILT on i_filter_buf_done.
REQ-014 SHALL define row need as follows:
- base = o_row*stride; k = i_k1x1 ? 0 : 1.
- Output row o_row requires input rows max(base-k,0) .. min(base+k,H-1).
REQ-015 SHALL prefetch IFM rows as follows:
- Counter next_ld issues rows in ascending order, one outstanding request at a time.
- Next request is no earlier than the cycle after i_ifm_buf_done.
- Conditions: busy, not in LOAD_FILT/DONE, next_ld <= H-1, and next_ld < max(base-k,0) + IFM_BUF_CNT.
- o_ifm_req_slot = next_ld mod IFM_BUF_CNT.
REQ-016 SHALL go HSYNC -> DATA after HSYNC_DLY cycles, and only once every required row of o_row has completed loading; otherwise it holds in HSYNC.
REQ-017 SHALL iterate DATA one beat per cycle, with o_chn outer (0..in_chn-1) and o_col inner (0..OW-1).
REQ-018 SHALL increment o_data_count by 1 per beat.
REQ-019 SHALL make the boundary flags combinational decodes of the current indices, valid while o_data_run = 1.
REQ-020 SHALL enter WAIT_PE after the last beat of a row and leave it on i_pe_done.
REQ-021 SHALL, on leaving WAIT_PE:
- go to HSYNC with o_row+1 if rows remain;
- else go to LOAD_FILT with o_otile+1 if tiles remain, resetting o_row and next_ld to 0;
- else go to DONE.
REQ-022 SHALL pulse o_end_frame for 1 cycle in DONE, then go to IDLE with o_busy = 0.
REQ-023 SHALL ignore i_pe_done outside WAIT_PE, i_filter_buf_done outside LOAD_FILT, and i_ifm_buf_done with no request outstanding.
REQ-024 SHALL accept i_ifm_buf_done in any busy state, including on the same cycle as a state transition.

Reset
REQ-025 SHALL, while rst = 1 at a clk edge, set the FSM to IDLE and zero all outputs, counters, the outstanding flag and next_ld.
REQ-026 SHALL apply reset mid-run: pending requests are abandoned, and a later completion pulse is ignored.

Verification
REQ-027 SHALL cover: W=8, H=4, in_chn=2, out_chn=1, stride 1, 3x3 -> IFM rows 0,1,2,3 in slots 0,1,2,3; final o_data_count = 64; one o_end_frame.
REQ-028 SHALL cover: W=8, H=8, stride2, 3x3, in_chn=2 -> o_col spans 0..3, o_row spans 0..3; final o_data_count = 32.
REQ-029 SHALL cover: out_chn=3, W=4, H=4, in_chn=1 -> filter requests for tiles 0,1,2; each IFM row requested 3 times; o_data_count = 48.
REQ-030 SHALL cover: i_ifm_buf_done delayed 2048 cycles, H=16 -> no DATA before rows 0 and 1 load; next_ld never exceeds max(base-1,0)+3.
REQ-031 SHALL cover: rst asserted mid-DATA -> all outputs 0 in the next cycle; a new i_start then repeats scenario REQ-027 exactly.
REQ-032 SHALL cover: i_start with i_width = 0 -> o_end_frame one cycle later; no requests issued.

Source files
------------

// File: rtl/cnn_tile_ctrl.sv
// CNN tile sequencer: per output tile loads filters, prefetches IFM rows into a
// ring buffer and issues data beats per output row (channel outer, column inner).
module cnn_tile_ctrl #(
  parameter int W_SIZE       = 9,
  parameter int W_CHANNEL    = 5,
  parameter int W_FRAME_SIZE = 24,
  parameter int W_IFM_BUF    = 2,
  parameter int HSYNC_DLY    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [W_SIZE-1:0]       i_width,
  input  logic [W_SIZE-1:0]       i_height,
  input  logic [W_CHANNEL-1:0]    i_in_chn,
  input  logic [W_CHANNEL-1:0]    i_out_chn,
  input  logic                    i_stride2,
  input  logic                    i_k1x1,
  input  logic                    i_ifm_buf_done,
  input  logic                    i_filter_buf_done,
  input  logic                    i_pe_done,
  output logic                    o_busy,
  output logic                    o_filter_req_load,
  output logic [W_CHANNEL-1:0]    o_filter_req_tile,
  output logic                    o_ifm_req_load,
  output logic [W_SIZE-1:0]       o_ifm_req_row,
  output logic [W_IFM_BUF-1:0]    o_ifm_req_slot,
  output logic                    o_hsync_run,
  output logic                    o_data_run,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_CHANNEL-1:0]    o_chn,
  output logic [W_CHANNEL-1:0]    o_otile,
  output logic                    o_is_first_row,
  output logic                    o_is_last_row,
  output logic                    o_is_first_col,
  output logic                    o_is_last_col,
  output logic                    o_is_first_chn,
  output logic                    o_is_last_chn,
  output logic [W_FRAME_SIZE-1:0] o_data_count,
  output logic                    o_end_frame
);
  localparam int IFM_BUF_CNT = 1 << W_IFM_BUF;
  localparam int W_HS        = $clog2(HSYNC_DLY + 1) + 1;

  typedef enum logic [2:0] {IDLE, LOAD_FILT, HSYNC, DATA, WAIT_PE, DONE} state_e;

  state_e                  state_q, state_d;
  logic [W_SIZE-1:0]       oh_q, oh_d, ow_q, ow_d, h_q, h_d;
  logic [W_SIZE-1:0]       row_q, row_d, col_q, col_d;
  logic [W_CHANNEL-1:0]    in_chn_q, in_chn_d, out_chn_q, out_chn_d;
  logic [W_CHANNEL-1:0]    chn_q, chn_d, otile_q, otile_d;
  logic                    stride2_q, stride2_d, k1x1_q, k1x1_d;
  logic [W_FRAME_SIZE-1:0] cnt_q, cnt_d;
  logic [W_HS-1:0]         hs_q, hs_d;
  logic [W_SIZE:0]         next_ld_q, next_ld_d, rows_done_q, rows_done_d;
  logic                    outst_q, outst_d, stale_q, stale_d;
  logic                    filt_req_q, filt_req_d, end_q, end_d;

  logic [W_SIZE:0]         oh_in, ow_in, base, low, hi_raw, h_last, hi;
  logic [W_SIZE+1:0]       win_end;
  logic                    rows_ready, ifm_req, cfg_zero;

  assign oh_in    = i_stride2 ? (({1'b0, i_height} + 1'b1) >> 1) : {1'b0, i_height};
  assign ow_in    = i_stride2 ? (({1'b0, i_width} + 1'b1) >> 1) : {1'b0, i_width};
  assign cfg_zero = (i_width == '0) || (i_height == '0) || (i_in_chn == '0) || (i_out_chn == '0);

  // Input row window needed by the current output row, and the ring-buffer limit
  assign base       = stride2_q ? {row_q, 1'b0} : {1'b0, row_q};
  assign low        = (!k1x1_q && base != '0) ? base - 1'b1 : base;
  assign hi_raw     = k1x1_q ? base : base + 1'b1;
  assign h_last     = {1'b0, h_q} - 1'b1;
  assign hi         = (hi_raw > h_last) ? h_last : hi_raw;
  assign rows_ready = rows_done_q > hi;
  assign win_end    = {1'b0, low} + (W_SIZE+2)'(IFM_BUF_CNT);
  assign ifm_req    = (state_q inside {HSYNC, DATA, WAIT_PE}) && !outst_q &&
                      (next_ld_q < {1'b0, h_q}) && ({1'b0, next_ld_q} < win_end);

  always_comb begin
    state_d     = state_q;
    oh_d        = oh_q;
    ow_d        = ow_q;
    h_d         = h_q;
    row_d       = row_q;
    col_d       = col_q;
    in_chn_d    = in_chn_q;
    out_chn_d   = out_chn_q;
    chn_d       = chn_q;
    otile_d     = otile_q;
    stride2_d   = stride2_q;
    k1x1_d      = k1x1_q;
    cnt_d       = cnt_q;
    hs_d        = hs_q;
    next_ld_d   = next_ld_q;
    rows_done_d = rows_done_q;
    outst_d     = outst_q;
    stale_d     = stale_q;
    filt_req_d  = 1'b0;
    end_d       = 1'b0;

    // A completion for a row requested before a tile switch or restart is dropped
    if (i_ifm_buf_done && outst_q) begin
      outst_d = 1'b0;
      stale_d = 1'b0;
      if (!stale_q) rows_done_d = rows_done_q + 1'b1;
    end else if (ifm_req) begin
      outst_d   = 1'b1;
      next_ld_d = next_ld_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (cfg_zero) begin
            end_d = 1'b1;
          end else begin
            oh_d        = oh_in[W_SIZE-1:0];
            ow_d        = ow_in[W_SIZE-1:0];
            h_d         = i_height;
            in_chn_d    = i_in_chn;
            out_chn_d   = i_out_chn;
            stride2_d   = i_stride2;
            k1x1_d      = i_k1x1;
            row_d       = '0;
            col_d       = '0;
            chn_d       = '0;
            otile_d     = '0;
            cnt_d       = '0;
            next_ld_d   = '0;
            rows_done_d = '0;
            stale_d     = outst_d;
            filt_req_d  = 1'b1;
            state_d     = LOAD_FILT;
          end
        end
      end
      LOAD_FILT: begin
        if (i_filter_buf_done) begin
          hs_d    = '0;
          state_d = HSYNC;
        end
      end
      HSYNC: begin
        if (int'(hs_q) < HSYNC_DLY) hs_d = hs_q + 1'b1;
        if ((int'(hs_q) + 1 >= HSYNC_DLY) && rows_ready) begin
          col_d   = '0;
          chn_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (col_q == ow_q - 1'b1) begin
          col_d = '0;
          if (chn_q == in_chn_q - 1'b1) begin
            chn_d   = '0;
            state_d = WAIT_PE;
          end else begin
            chn_d = chn_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      WAIT_PE: begin
        if (i_pe_done) begin
          if (row_q != oh_q - 1'b1) begin
            row_d   = row_q + 1'b1;
            hs_d    = '0;
            state_d = HSYNC;
          end else if (otile_q != out_chn_q - 1'b1) begin
            otile_d     = otile_q + 1'b1;
            row_d       = '0;
            next_ld_d   = '0;
            rows_done_d = '0;
            stale_d     = outst_d;
            filt_req_d  = 1'b1;
            state_d     = LOAD_FILT;
          end else begin
            end_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      oh_q        <= '0;
      ow_q        <= '0;
      h_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      in_chn_q    <= '0;
      out_chn_q   <= '0;
      chn_q       <= '0;
      otile_q     <= '0;
      stride2_q   <= 1'b0;
      k1x1_q      <= 1'b0;
      cnt_q       <= '0;
      hs_q        <= '0;
      next_ld_q   <= '0;
      rows_done_q <= '0;
      outst_q     <= 1'b0;
      stale_q     <= 1'b0;
      filt_req_q  <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      oh_q        <= oh_d;
      ow_q        <= ow_d;
      h_q         <= h_d;
      row_q       <= row_d;
      col_q       <= col_d;
      in_chn_q    <= in_chn_d;
      out_chn_q   <= out_chn_d;
      chn_q       <= chn_d;
      otile_q     <= otile_d;
      stride2_q   <= stride2_d;
      k1x1_q      <= k1x1_d;
      cnt_q       <= cnt_d;
      hs_q        <= hs_d;
      next_ld_q   <= next_ld_d;
      rows_done_q <= rows_done_d;
      outst_q     <= outst_d;
      stale_q     <= stale_d;
      filt_req_q  <= filt_req_d;
      end_q       <= end_d;
    end
  end

  assign o_busy            = (state_q != IDLE);
  assign o_filter_req_load = filt_req_q;
  assign o_filter_req_tile = otile_q;
  assign o_ifm_req_load    = ifm_req;
  assign o_ifm_req_row     = next_ld_q[W_SIZE-1:0];
  assign o_ifm_req_slot    = next_ld_q[W_IFM_BUF-1:0];
  assign o_hsync_run       = (state_q == HSYNC);
  assign o_data_run        = (state_q == DATA);
  assign o_row             = row_q;
  assign o_col             = col_q;
  assign o_chn             = chn_q;
  assign o_otile           = otile_q;
  assign o_is_first_row    = o_data_run && (row_q == '0);
  assign o_is_last_row     = o_data_run && (row_q == oh_q - 1'b1);
  assign o_is_first_col    = o_data_run && (col_q == '0);
  assign o_is_last_col     = o_data_run && (col_q == ow_q - 1'b1);
  assign o_is_first_chn    = o_data_run && (chn_q == '0);
  assign o_is_last_chn     = o_data_run && (chn_q == in_chn_q - 1'b1);
  assign o_data_count      = cnt_q;
  assign o_end_frame       = end_q;
endmodule
